// File: rtl/dram_arb_pkg.sv
// Shared types and MDR control encodings for the DRAM access arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  localparam logic [1:0] MDR_HOLD      = 2'b00;
  localparam logic [1:0] MDR_FROM_DRAM = 2'b01;
  localparam logic [1:0] MDR_FROM_BUS  = 2'b10;

endpackage

// File: rtl/dram_arb_rr.sv
// Two-way round-robin grant between CPU and loader, remembering the last winner.
// Optional DRAM_ARB_LOCK_EN adds ldr_lock, which keeps the CPU out during loader bursts.
module dram_arb_rr
  import dram_arb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   cpu_req,
  input  logic   ldr_req,
`ifdef DRAM_ARB_LOCK_EN
  input  logic   ldr_lock,
`endif
  input  logic   grant_en,
  output logic   grant_vld,
  output owner_e grant_owner
);

  owner_e last_grant_q, last_grant_d;
  logic   cpu_ok;

  always_comb begin
    cpu_ok = cpu_req;
`ifdef DRAM_ARB_LOCK_EN
    if (ldr_lock && (last_grant_q == OWN_LDR)) cpu_ok = 1'b0;
`endif
    grant_vld = cpu_ok | ldr_req;
    if (cpu_ok && ldr_req) begin
      grant_owner = (last_grant_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (cpu_ok) begin
      grant_owner = OWN_CPU;
    end else begin
      grant_owner = OWN_LDR;
    end
    last_grant_d = last_grant_q;
    if (grant_en && grant_vld) last_grant_d = grant_owner;
  end

  // Starting from LDR lets the CPU win the first tie after reset.
  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= OWN_LDR;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dram_access_arbiter.sv
// Shares the image DRAM port between CPU (through the MDR) and the UART loader.
// Optional DRAM_ARB_LOCK_EN adds the ldr_lock input for uninterrupted loader bursts.
module dram_access_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_mdr_from_bus,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
`ifdef DRAM_ARB_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic              dram_wsel,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [1:0]        mdr_control
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
  logic              dram_we_q, dram_we_d;
  logic              dram_wsel_q, dram_wsel_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic              grant_vld;
  owner_e            grant_owner;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;

  // Loader write data is steered to the DRAM by dram_wsel outside this block.
  logic              unused_wdata;
  assign unused_wdata = ^ldr_wdata;

  dram_arb_rr u_rr (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
`ifdef DRAM_ARB_LOCK_EN
    .ldr_lock    (ldr_lock),
`endif
    .grant_en    (state_q == IDLE),
    .grant_vld   (grant_vld),
    .grant_owner (grant_owner)
  );

  assign req_we   = (grant_owner == OWN_CPU) ? cpu_we   : ldr_we;
  assign req_addr = (grant_owner == OWN_CPU) ? cpu_addr : ldr_addr;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    dram_addr_d = dram_addr_q;
    dram_we_d   = 1'b0;
    dram_wsel_d = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d     = grant_owner;
          dram_addr_d = req_addr;
          if (req_we) begin
            state_d     = WRITE;
            dram_we_d   = 1'b1;
            dram_wsel_d = (grant_owner == OWN_LDR);
            cpu_ack_d   = (grant_owner == OWN_CPU);
            ldr_ack_d   = (grant_owner == OWN_LDR);
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WRITE: state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d   = CAPTURE;
          cpu_ack_d = (owner_q == OWN_CPU);
          ldr_ack_d = (owner_q == OWN_LDR);
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is valid on dram_rdata during CAPTURE, so the loader sees it in the ack cycle.
  always_comb begin
    ldr_rdata_d = ldr_rdata_q;
    if ((state_q == CAPTURE) && (owner_q == OWN_LDR)) ldr_rdata_d = dram_rdata;
  end

  always_comb begin
    mdr_control = cpu_mdr_from_bus ? MDR_FROM_BUS : MDR_HOLD;
    if ((state_q == CAPTURE) && (owner_q == OWN_CPU))    mdr_control = MDR_FROM_DRAM;
    else if ((state_q == WRITE) && (owner_q == OWN_CPU)) mdr_control = MDR_HOLD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= 2'd0;
      dram_addr_q <= '0;
      dram_we_q   <= 1'b0;
      dram_wsel_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      dram_addr_q <= dram_addr_d;
      dram_we_q   <= dram_we_d;
      dram_wsel_q <= dram_wsel_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign ldr_rdata = ldr_rdata_d;
  assign dram_addr = dram_addr_q;
  assign dram_we   = dram_we_q;
  assign dram_wsel = dram_wsel_q;

`ifndef SYNTHESIS
  // A bus->MDR load requested while the CPU owns a DRAM transfer is overridden.
  always_ff @(posedge clock) begin
    if (!reset && cpu_mdr_from_bus && (owner_q == OWN_CPU))
      assert (!((state_q == CAPTURE) || (state_q == WRITE)))
        else $warning("bus->MDR load overridden by a CPU DRAM transfer");
  end
`endif

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Bench for dram_access_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dram_access_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clock;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_mdr_from_bus;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic              ldr_req, ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
`ifdef DRAM_ARB_LOCK_EN
  logic              ldr_lock;
`endif
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_we, dram_wsel;
  logic [DATA_W-1:0] dram_rdata;
  logic [1:0]        mdr_control;

  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] bus_data;

  int vectors;
  int miscompares;

  dram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_mdr_from_bus (cpu_mdr_from_bus),
    .cpu_ack          (cpu_ack),
    .ldr_req          (ldr_req),
    .ldr_we           (ldr_we),
    .ldr_addr         (ldr_addr),
    .ldr_wdata        (ldr_wdata),
`ifdef DRAM_ARB_LOCK_EN
    .ldr_lock         (ldr_lock),
`endif
    .ldr_ack          (ldr_ack),
    .ldr_rdata        (ldr_rdata),
    .dram_addr        (dram_addr),
    .dram_we          (dram_we),
    .dram_wsel        (dram_wsel),
    .dram_rdata       (dram_rdata),
    .mdr_control      (mdr_control)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment MDR register driven by mdr_control.
  always @(posedge clock) begin
    if (reset) mdr <= '0;
    else if (mdr_control == 2'b01) mdr <= dram_rdata;
    else if (mdr_control == 2'b10) mdr <= bus_data;
  end

  task automatic zero_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_mdr_from_bus = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; dram_rdata = '0;
`ifdef DRAM_ARB_LOCK_EN
    ldr_lock = 0;
`endif
  endtask

  // Leaves the bench at the drive point (just after posedge) of the first IDLE cycle.
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; zero_inputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1; zero_inputs();
    cpu_req = 1; ldr_req = 1; cpu_addr = 16'hBEEF; ldr_addr = 16'h1234;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset cpu_ack: got %b want 0", cpu_ack); end
    vectors++; if (ldr_ack !== 1'b0) begin miscompares++; $display("FAIL reset ldr_ack: got %b want 0", ldr_ack); end
    vectors++; if (dram_we !== 1'b0) begin miscompares++; $display("FAIL reset dram_we: got %b want 0", dram_we); end
    vectors++; if (dram_wsel !== 1'b0) begin miscompares++; $display("FAIL reset dram_wsel: got %b want 0", dram_wsel); end
    vectors++; if (dram_addr !== 16'h0) begin miscompares++; $display("FAIL reset dram_addr: got %h want 0", dram_addr); end
    vectors++; if (ldr_rdata !== 8'h0) begin miscompares++; $display("FAIL reset ldr_rdata: got %h want 0", ldr_rdata); end
    vectors++; if (mdr_control !== 2'b00) begin miscompares++; $display("FAIL reset mdr_control: got %b want 00", mdr_control); end
    @(posedge clock); #1;
    reset = 0; zero_inputs();
  endtask

  task automatic test_cpu_read();
    int ack_at, n_ack, n_ldr;
    logic [1:0] mdr_at_ack;
    logic [ADDR_W-1:0] addr_at_ack;
    logic [DATA_W-1:0] mdr_after;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; dram_rdata = 8'hA5;
    ack_at = -1; n_ack = 0; n_ldr = 0; mdr_at_ack = 2'bxx; addr_at_ack = 'x; mdr_after = 'x;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (ack_at >= 0 && k == ack_at + 1) mdr_after = mdr;
      if (cpu_ack) begin
        n_ack++;
        if (ack_at < 0) begin ack_at = k; mdr_at_ack = mdr_control; addr_at_ack = dram_addr; end
      end
      if (ldr_ack) n_ldr++;
      @(posedge clock); #1;
      if (ack_at >= 0) cpu_req = 0;
    end
    vectors++; if (ack_at != RD_LAT + 1) begin miscompares++; $display("FAIL cpu_read ack cycle: got T+%0d want T+%0d", ack_at, RD_LAT + 1); end
    vectors++; if (n_ack != 1) begin miscompares++; $display("FAIL cpu_read ack pulses: got %0d want 1", n_ack); end
    vectors++; if (n_ldr != 0) begin miscompares++; $display("FAIL cpu_read ldr_ack pulses: got %0d want 0", n_ldr); end
    vectors++; if (mdr_at_ack !== 2'b01) begin miscompares++; $display("FAIL cpu_read mdr_control: got %b want 01", mdr_at_ack); end
    vectors++; if (addr_at_ack !== 16'h0010) begin miscompares++; $display("FAIL cpu_read dram_addr: got %h want 0010", addr_at_ack); end
    vectors++; if (mdr_after !== 8'hA5) begin miscompares++; $display("FAIL cpu_read MDR: got %h want a5", mdr_after); end
  endtask

  task automatic test_round_robin();
    int ack_cyc[$];
    int ack_own[$];
    int exp_t, exp_o;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0200; ldr_wdata = 8'h11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (cpu_ack) begin ack_cyc.push_back(k); ack_own.push_back(0); end
      if (ldr_ack) begin ack_cyc.push_back(k); ack_own.push_back(1); end
      @(posedge clock); #1;
    end
    zero_inputs();
    vectors++; if (ack_cyc.size() < 6) begin miscompares++; $display("FAIL rr ack count: got %0d want >=6", ack_cyc.size()); end
    exp_t = 0;
    for (int i = 0; i < 6 && i < ack_cyc.size(); i++) begin
      exp_o = i % 2;
      if (i == 0) exp_t = RD_LAT + 1;
      else if (exp_o == 0) exp_t = exp_t + RD_LAT + 2;
      else exp_t = exp_t + 2;
      vectors++; if (ack_own[i] != exp_o) begin miscompares++; $display("FAIL rr owner #%0d: got %0d want %0d", i, ack_own[i], exp_o); end
      vectors++; if (ack_cyc[i] != exp_t) begin miscompares++; $display("FAIL rr ack cycle #%0d: got %0d want %0d", i, ack_cyc[i], exp_t); end
    end
  endtask

  task automatic test_ldr_write();
    do_reset();
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0100; ldr_wdata = 8'h3C;
    @(negedge clock);
    vectors++; if (dram_we !== 1'b0 || ldr_ack !== 1'b0) begin miscompares++; $display("FAIL ldr_write grant cycle: got we=%b ack=%b want 0 0", dram_we, ldr_ack); end
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (dram_we !== 1'b1) begin miscompares++; $display("FAIL ldr_write dram_we: got %b want 1", dram_we); end
    vectors++; if (dram_wsel !== 1'b1) begin miscompares++; $display("FAIL ldr_write dram_wsel: got %b want 1", dram_wsel); end
    vectors++; if (ldr_ack !== 1'b1) begin miscompares++; $display("FAIL ldr_write ldr_ack: got %b want 1", ldr_ack); end
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL ldr_write cpu_ack: got %b want 0", cpu_ack); end
    vectors++; if (dram_addr !== 16'h0100) begin miscompares++; $display("FAIL ldr_write dram_addr: got %h want 0100", dram_addr); end
    vectors++; if (mdr_control !== 2'b00) begin miscompares++; $display("FAIL ldr_write mdr_control: got %b want 00", mdr_control); end
    @(posedge clock); #1;
    ldr_req = 0;
    @(negedge clock);
    vectors++; if (dram_we !== 1'b0 || ldr_ack !== 1'b0) begin miscompares++; $display("FAIL ldr_write after: got we=%b ack=%b want 0 0", dram_we, ldr_ack); end
    vectors++; if (dram_addr !== 16'h0100) begin miscompares++; $display("FAIL ldr_write addr hold: got %h want 0100", dram_addr); end
    @(posedge clock); #1;
  endtask

  task automatic test_bus_collision();
    logic [1:0] exp_m;
    do_reset();
    cpu_mdr_from_bus = 1;
    @(negedge clock);
    vectors++; if (mdr_control !== 2'b10) begin miscompares++; $display("FAIL bus idle mdr_control: got %b want 10", mdr_control); end
    @(posedge clock); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      @(negedge clock);
      exp_m = (k == RD_LAT + 1) ? 2'b01 : 2'b10;
      vectors++; if (mdr_control !== exp_m) begin miscompares++; $display("FAIL bus read mdr_control T+%0d: got %b want %b", k, mdr_control, exp_m); end
      @(posedge clock); #1;
    end
    cpu_req = 0;
    @(negedge clock);
    @(posedge clock); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0031;
    @(negedge clock);
    vectors++; if (mdr_control !== 2'b10) begin miscompares++; $display("FAIL bus write grant mdr_control: got %b want 10", mdr_control); end
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (mdr_control !== 2'b00) begin miscompares++; $display("FAIL bus write mdr_control: got %b want 00", mdr_control); end
    vectors++; if (cpu_ack !== 1'b1 || dram_wsel !== 1'b0) begin miscompares++; $display("FAIL bus write ack/wsel: got %b/%b want 1/0", cpu_ack, dram_wsel); end
    @(posedge clock); #1;
    cpu_req = 0;
    @(negedge clock);
    vectors++; if (mdr_control !== 2'b10) begin miscompares++; $display("FAIL bus after write mdr_control: got %b want 10", mdr_control); end
    @(posedge clock); #1;
    cpu_mdr_from_bus = 0;
  endtask

  task automatic test_reset_mid();
    int n_ack, n_we;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    @(posedge clock); #1;
    @(negedge clock);
    vectors++; if (dram_addr !== 16'h1234) begin miscompares++; $display("FAIL rst_mid addr before: got %h want 1234", dram_addr); end
    reset = 1; cpu_req = 0;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    vectors++; if (dram_addr !== 16'h0) begin miscompares++; $display("FAIL rst_mid dram_addr: got %h want 0", dram_addr); end
    vectors++; if ({cpu_ack, ldr_ack, dram_we, dram_wsel} !== 4'b0) begin miscompares++; $display("FAIL rst_mid strobes: got %b want 0000", {cpu_ack, ldr_ack, dram_we, dram_wsel}); end
    vectors++; if (mdr_control !== 2'b00 || ldr_rdata !== 8'h0) begin miscompares++; $display("FAIL rst_mid mdr/rdata: got %b/%h want 00/00", mdr_control, ldr_rdata); end
    n_ack = 0; n_we = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      if (cpu_ack || ldr_ack) n_ack++;
      if (dram_we) n_we++;
    end
    vectors++; if (n_ack != 0 || n_we != 0) begin miscompares++; $display("FAIL rst_mid late activity: got ack=%0d we=%0d want 0 0", n_ack, n_we); end
    @(posedge clock); #1;
  endtask

`ifdef DRAM_ARB_LOCK_EN
  task automatic test_lock();
    int n_ldr, n_ldr_at_cpu, drop_k, cpu_k;
    do_reset();
    ldr_lock = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040;
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0400; ldr_wdata = 8'h77;
    n_ldr = 0; n_ldr_at_cpu = -1; drop_k = -1; cpu_k = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (ldr_ack) n_ldr++;
      if (cpu_ack && cpu_k < 0) begin cpu_k = k; n_ldr_at_cpu = n_ldr; end
      @(posedge clock); #1;
      if (n_ldr == 4 && drop_k < 0) begin ldr_lock = 0; drop_k = k + 1; end
    end
    zero_inputs();
    vectors++; if (drop_k < 0) begin miscompares++; $display("FAIL lock loader grants: got %0d want 4 before timeout", n_ldr); end
    vectors++; if (n_ldr_at_cpu != 4) begin miscompares++; $display("FAIL lock loader grants before cpu: got %0d want 4", n_ldr_at_cpu); end
    vectors++; if (cpu_k != drop_k + 1) begin miscompares++; $display("FAIL lock cpu ack cycle: got %0d want %0d", cpu_k, drop_k + 1); end
  endtask
`endif

  // Transaction-level model: one access at a time, grant when free, fixed completion delay.
  task automatic test_random();
    bit busy, own, twe, last, cpu_done, ldr_done, fin;
    int ack_c;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_rd;
    logic [1:0] exp_m;
    bit e_cack, e_lack, e_we;
    do_reset();
    busy = 0; own = 0; twe = 0; last = 1; cpu_done = 0; ldr_done = 0; ack_c = -1;
    exp_addr = '0; exp_rd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cpu_done) begin cpu_req = 0; cpu_done = 0; end
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom);
      end else if (busy && !own && cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom);
      end
      if (ldr_done) begin ldr_req = 0; ldr_done = 0; end
      else if (!ldr_req && $urandom_range(0, 2) == 0) begin
        ldr_req = 1; ldr_we = 1'($urandom_range(0, 1)); ldr_addr = 16'($urandom); ldr_wdata = 8'($urandom);
      end else if (busy && own && ldr_req && $urandom_range(0, 3) == 0) begin
        ldr_we = 1'($urandom_range(0, 1)); ldr_addr = 16'($urandom);
      end
      cpu_mdr_from_bus = ($urandom_range(0, 3) == 0);
      dram_rdata = 8'($urandom);
      @(negedge clock);
      fin = busy && (cyc == ack_c);
      e_cack = fin && !own;
      e_lack = fin && own;
      e_we = fin && twe;
      exp_m = cpu_mdr_from_bus ? 2'b10 : 2'b00;
      if (fin && !own) exp_m = twe ? 2'b00 : 2'b01;
      if (fin && own && !twe) exp_rd = dram_rdata;
      vectors++; if (cpu_ack !== e_cack) begin miscompares++; $display("FAIL rnd cpu_ack cyc %0d: got %b want %b", cyc, cpu_ack, e_cack); end
      vectors++; if (ldr_ack !== e_lack) begin miscompares++; $display("FAIL rnd ldr_ack cyc %0d: got %b want %b", cyc, ldr_ack, e_lack); end
      vectors++; if (dram_we !== e_we) begin miscompares++; $display("FAIL rnd dram_we cyc %0d: got %b want %b", cyc, dram_we, e_we); end
      if (e_we) begin
        vectors++; if (dram_wsel !== own) begin miscompares++; $display("FAIL rnd dram_wsel cyc %0d: got %b want %b", cyc, dram_wsel, own); end
      end
      vectors++; if (dram_addr !== exp_addr) begin miscompares++; $display("FAIL rnd dram_addr cyc %0d: got %h want %h", cyc, dram_addr, exp_addr); end
      vectors++; if (ldr_rdata !== exp_rd) begin miscompares++; $display("FAIL rnd ldr_rdata cyc %0d: got %h want %h", cyc, ldr_rdata, exp_rd); end
      vectors++; if (mdr_control !== exp_m) begin miscompares++; $display("FAIL rnd mdr_control cyc %0d: got %b want %b", cyc, mdr_control, exp_m); end
      if (fin) begin
        busy = 0;
        if (own) ldr_done = 1; else cpu_done = 1;
      end else if (!busy && (cpu_req || ldr_req)) begin
        own = (cpu_req && ldr_req) ? ~last : ldr_req;
        last = own;
        busy = 1;
        twe = own ? ldr_we : cpu_we;
        exp_addr = own ? ldr_addr : cpu_addr;
        ack_c = cyc + (twe ? 1 : RD_LAT + 1);
      end
      @(posedge clock); #1;
    end
    zero_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    bus_data = 8'h5A;
    reset = 1;
    zero_inputs();
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_ldr_write();
    test_bus_collision();
    test_reset_mid();
`ifdef DRAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
